// File: rtl/subservient_sram_bridge.sv
// Bridges the RF RAM port and a 32-bit Wishbone slave onto one 1R1W SRAM macro.
// Wishbone words become 32/dw sequential beats; RF strobes always take priority.
module subservient_sram_bridge #(
  parameter int depth = 512,
  parameter int dw    = 8,
  parameter int saw   = $clog2(depth*8/dw)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [saw-1:0]              i_rf_waddr,
  input  logic [dw-1:0]               i_rf_wdata,
  input  logic                        i_rf_wen,
  input  logic [saw-1:0]              i_rf_raddr,
  input  logic                        i_rf_ren,
  output logic [dw-1:0]               o_rf_rdata,
  input  logic [$clog2(depth)-3:0]    i_wb_adr,
  input  logic [31:0]                 i_wb_dat,
  input  logic [3:0]                  i_wb_sel,
  input  logic                        i_wb_we,
  input  logic                        i_wb_stb,
  output logic [31:0]                 o_wb_rdt,
  output logic                        o_wb_ack,
  output logic [saw-1:0]              o_sram_waddr,
  output logic [dw-1:0]               o_sram_wdata,
  output logic [dw/8-1:0]             o_sram_wmask,
  output logic                        o_sram_wen,
  output logic [saw-1:0]              o_sram_raddr,
  input  logic [dw-1:0]               i_sram_rdata,
  output logic                        o_sram_ren
);

  localparam int nb = 32 / dw;
  localparam int bw = (nb > 1) ? $clog2(nb) : 1;
  localparam int aw = $clog2(depth) - 2;
  localparam int mw = dw / 8;
  localparam logic [bw-1:0] last_beat = bw'(nb - 1);

  localparam logic [2:0] st_idle   = 3'd0;
  localparam logic [2:0] st_wr     = 3'd1;
  localparam logic [2:0] st_rd     = 3'd2;
  localparam logic [2:0] st_rdlast = 3'd3;
  localparam logic [2:0] st_ack    = 3'd4;

  logic [2:0]     state_r;
  logic [2:0]     next_s;
  logic [aw-1:0]  adr_r;
  logic [31:0]    dat_r;
  logic [3:0]     sel_r;
  logic [bw-1:0]  beat_r;
  logic           pend_r;
  logic [bw-1:0]  pend_beat_r;
  logic [31:0]    rdt_r;
  logic           ack_r;

  logic [saw-1:0] beat_addr_s;
  logic [dw-1:0]  beat_data_s;
  logic [mw-1:0]  beat_sel_s;
  logic           wr_go_s;
  logic           rd_go_s;

  assign beat_addr_s = saw'(adr_r) * saw'(nb) + saw'(beat_r);
  assign beat_data_s = dat_r[int'(beat_r)*dw +: dw];
  assign beat_sel_s  = sel_r[int'(beat_r)*mw +: mw];

  // An all-zero select beat needs no port, so it advances even under an RF write.
  assign wr_go_s = (state_r == st_wr) && (!i_rf_wen || (beat_sel_s == {mw{1'b0}}));
  assign rd_go_s = (state_r == st_rd) && !i_rf_ren;

  assign o_rf_rdata = i_sram_rdata;
  assign o_wb_rdt   = rdt_r;
  assign o_wb_ack   = ack_r;

  // Write port arbitration: RF first, then the current Wishbone write beat.
  always_comb begin
    o_sram_waddr = i_rf_waddr;
    o_sram_wdata = i_rf_wdata;
    o_sram_wmask = {mw{1'b1}};
    o_sram_wen   = 1'b0;
    if (i_rf_wen) begin
      o_sram_wen = 1'b1;
    end else if (state_r == st_wr) begin
      o_sram_waddr = beat_addr_s;
      o_sram_wdata = beat_data_s;
      o_sram_wmask = beat_sel_s;
      o_sram_wen   = |beat_sel_s;
    end else begin
      o_sram_wen = 1'b0;
    end
  end

  // Read port arbitration: RF first, then the current Wishbone read beat.
  always_comb begin
    o_sram_raddr = i_rf_raddr;
    o_sram_ren   = 1'b0;
    if (i_rf_ren) begin
      o_sram_ren = 1'b1;
    end else if (state_r == st_rd) begin
      o_sram_raddr = beat_addr_s;
      o_sram_ren   = 1'b1;
    end else begin
      o_sram_ren = 1'b0;
    end
  end

  // Transaction sequencing.
  always_comb begin
    next_s = state_r;
    case (state_r)
      st_idle:   next_s = i_wb_stb ? (i_wb_we ? st_wr : st_rd) : st_idle;
      st_wr:     next_s = (wr_go_s && (beat_r == last_beat)) ? st_ack : st_wr;
      st_rd:     next_s = (rd_go_s && (beat_r == last_beat)) ? st_rdlast : st_rd;
      st_rdlast: next_s = st_ack;
      st_ack:    next_s = st_idle;
      default:   next_s = st_idle;
    endcase
  end

  // State, request latch, beat counter and read-data assembly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= st_idle;
      adr_r       <= {aw{1'b0}};
      dat_r       <= 32'h0000_0000;
      sel_r       <= 4'b0000;
      beat_r      <= {bw{1'b0}};
      pend_r      <= 1'b0;
      pend_beat_r <= {bw{1'b0}};
      rdt_r       <= 32'h0000_0000;
      ack_r       <= 1'b0;
    end else begin
      state_r <= next_s;
      ack_r   <= (next_s == st_ack);
      if (state_r == st_idle) begin
        if (i_wb_stb) begin
          adr_r  <= i_wb_adr;
          dat_r  <= i_wb_dat;
          sel_r  <= i_wb_sel;
          beat_r <= {bw{1'b0}};
        end
      end else if (wr_go_s || rd_go_s) begin
        beat_r <= (beat_r == last_beat) ? {bw{1'b0}} : beat_r + bw'(1);
      end
      // Data for a beat issued last cycle lands in its slice now.
      pend_r      <= rd_go_s;
      pend_beat_r <= beat_r;
      if (pend_r) begin
        rdt_r[int'(pend_beat_r)*dw +: dw] <= i_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_subservient_sram_bridge.sv
// Randomized bench for subservient_sram_bridge against a byte-array SRAM and
// a transaction-level model of beat stalls, RF reads and Wishbone data.
module tb_subservient_sram_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dw=8 instance
  logic [8:0]  rf_waddr, rf_raddr;
  logic [7:0]  rf_wdata, rf_rdata;
  logic        rf_wen, rf_ren;
  logic [6:0]  wb_adr;
  logic [31:0] wb_dat, wb_rdt;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_ack;
  logic [8:0]  sram_waddr, sram_raddr;
  logic [7:0]  sram_wdata, sram_rdata;
  logic [0:0]  sram_wmask;
  logic        sram_wen, sram_ren;

  subservient_sram_bridge #(.depth(512), .dw(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rf_waddr(rf_waddr), .i_rf_wdata(rf_wdata), .i_rf_wen(rf_wen),
    .i_rf_raddr(rf_raddr), .i_rf_ren(rf_ren), .o_rf_rdata(rf_rdata),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_stb(wb_stb), .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .o_sram_waddr(sram_waddr), .o_sram_wdata(sram_wdata), .o_sram_wmask(sram_wmask),
    .o_sram_wen(sram_wen), .o_sram_raddr(sram_raddr), .i_sram_rdata(sram_rdata),
    .o_sram_ren(sram_ren)
  );

  // dw=16 instance, directed only
  logic [7:0]  w16_waddr, w16_raddr;
  logic [15:0] w16_wdata, w16_q, w16_rf_rdata;
  logic [1:0]  w16_wmask;
  logic        w16_wen, w16_ren, w16_we, w16_stb, w16_ack;
  logic [6:0]  w16_adr;
  logic [31:0] w16_dat, w16_rdt;
  logic [3:0]  w16_sel;

  subservient_sram_bridge #(.depth(512), .dw(16)) dut16 (
    .i_clk(clk), .i_rst(rst),
    .i_rf_waddr(8'h00), .i_rf_wdata(16'h0000), .i_rf_wen(1'b0),
    .i_rf_raddr(8'h00), .i_rf_ren(1'b0), .o_rf_rdata(w16_rf_rdata),
    .i_wb_adr(w16_adr), .i_wb_dat(w16_dat), .i_wb_sel(w16_sel), .i_wb_we(w16_we),
    .i_wb_stb(w16_stb), .o_wb_rdt(w16_rdt), .o_wb_ack(w16_ack),
    .o_sram_waddr(w16_waddr), .o_sram_wdata(w16_wdata), .o_sram_wmask(w16_wmask),
    .o_sram_wen(w16_wen), .o_sram_raddr(w16_raddr), .i_sram_rdata(w16_q),
    .o_sram_ren(w16_ren)
  );

  // The 16-bit SRAM returns a fixed function of its address.
  always @(posedge clk) if (w16_ren) w16_q <= {8'h00, w16_raddr} ^ 16'hA5A5;

  logic [7:0] mem [512];
  logic       mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    end else if (sram_wen && sram_wmask[0]) begin
      mem[sram_waddr] <= sram_wdata;
    end
    if (sram_ren) sram_rdata <= mem[sram_raddr];
  end

  logic [7:0] ref_mem [512];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // mode 0: no RF traffic, 1: random RF traffic, 2: RF reads in T+2..T+4
  task automatic wb_txn(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int mode);
    logic        pw [48];
    logic        pr [48];
    logic [8:0]  pwa [48];
    logic [8:0]  pra [48];
    logic [7:0]  pwd [48];
    logic [16:0] exp_beats[$];
    logic [16:0] obs_beats[$];
    logic [31:0] exp_word, got_word;
    logic [7:0]  rd_exp;
    logic        rd_pend;
    int          b, c, exp_ack, ack_c;

    for (int i = 0; i < 48; i++) begin
      pw[i]  = (mode == 1) && (i > 0) && (i < 20) && ($urandom_range(2) == 0);
      pr[i]  = (mode == 1) ? ((i > 0) && (i < 20) && ($urandom_range(2) == 0))
                           : ((mode == 2) && (i >= 2) && (i <= 4));
      pwa[i] = {1'b1, 8'($urandom)};
      pra[i] = {1'b1, 8'($urandom)};
      pwd[i] = 8'($urandom);
    end

    // Beat b stalls while the RF holds the port it needs.
    b = 0; c = 0;
    if (we) begin
      while (b < 4) begin c++; if (!(pw[c] && sel[b])) b++; end
      exp_ack = c + 1;
    end else begin
      while (b < 4) begin c++; if (!pr[c]) b++; end
      exp_ack = c + 2;
    end
    for (int k = 0; k < 4; k++) begin
      if (we && sel[k]) exp_beats.push_back({9'(adr * 4 + k), dat[8*k +: 8]});
      else if (!we)     exp_beats.push_back({9'(adr * 4 + k), 8'h00});
    end
    exp_word = {ref_mem[adr*4+3], ref_mem[adr*4+2], ref_mem[adr*4+1], ref_mem[adr*4]};

    @(posedge clk); #1;
    wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    rf_wen = 1'b0; rf_ren = 1'b0;
    rd_pend = 1'b0; rd_exp = 8'h00; ack_c = -1; got_word = 32'h0;
    for (c = 1; c < 48; c++) begin
      @(posedge clk); #1;
      if (ack_c >= 0) begin
        wb_stb = 1'b0; rf_wen = 1'b0; rf_ren = 1'b0;
      end else begin
        rf_wen = pw[c]; rf_waddr = pwa[c]; rf_wdata = pwd[c];
        rf_ren = pr[c]; rf_raddr = pra[c];
      end
      @(negedge clk);
      if (rd_pend) check("rf_rdata", 32'(rf_rdata), 32'(rd_exp));
      rd_pend = rf_ren;
      if (rf_ren) begin
        rd_exp = ref_mem[rf_raddr];
        check("rf_raddr", 32'({sram_ren, sram_raddr}), 32'({1'b1, rf_raddr}));
      end else if (sram_ren) begin
        obs_beats.push_back({sram_raddr, 8'h00});
      end
      if (rf_wen) begin
        check("rf_wport", 32'({sram_wen, sram_wmask, sram_waddr, sram_wdata}),
              32'({1'b1, 1'b1, rf_waddr, rf_wdata}));
        ref_mem[rf_waddr] = rf_wdata;
      end else if (sram_wen) begin
        obs_beats.push_back({sram_waddr, sram_wdata});
      end
      if (ack_c >= 0) begin
        check("ack_single", 32'(wb_ack), 32'(0));
        check("idle_strobes", 32'({sram_wen, sram_ren}), 32'(0));
        break;
      end
      if (wb_ack) begin
        ack_c = c;
        got_word = wb_rdt;
      end
    end

    check("ack_latency", 32'(ack_c), 32'(exp_ack));
    check("beat_count", 32'(obs_beats.size()), 32'(exp_beats.size()));
    for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++)
      check("beat", 32'(obs_beats[i]), 32'(exp_beats[i]));
    if (!we) check("wb_rdt", got_word, exp_word);
    else for (int k = 0; k < 4; k++) if (sel[k]) ref_mem[adr*4+k] = dat[8*k +: 8];
  endtask

  initial begin
    logic saw_ack;
    rst = 1'b1; mem_clr = 1'b1;
    wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 7'h0; wb_dat = 32'h0; wb_sel = 4'h0;
    rf_wen = 1'b0; rf_ren = 1'b0; rf_waddr = 9'h0; rf_raddr = 9'h0; rf_wdata = 8'h0;
    w16_stb = 1'b0; w16_we = 1'b0; w16_adr = 7'h0; w16_dat = 32'h0; w16_sel = 4'h0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wb_ack), 32'(0));
    check("rst_rdt", wb_rdt, 32'h0);
    check("rst_strobes", 32'({sram_wen, sram_ren, w16_wen, w16_ren}), 32'(0));
    rst = 1'b0; mem_clr = 1'b0;

    // dw=16 write 0x11223344, sel 0110, adr 1
    @(posedge clk); #1;
    w16_stb = 1'b1; w16_we = 1'b1; w16_adr = 7'd1; w16_dat = 32'h1122_3344; w16_sel = 4'b0110;
    @(posedge clk); @(negedge clk);
    check("w16_beat0", 32'({w16_wen, w16_wmask, w16_waddr, w16_wdata}), {5'h0, 1'b1, 2'b10, 8'd2, 16'h3344});
    @(posedge clk); @(negedge clk);
    check("w16_beat1", 32'({w16_wen, w16_wmask, w16_waddr, w16_wdata}), {5'h0, 1'b1, 2'b01, 8'd3, 16'h1122});
    check("w16_wr_early", 32'(w16_ack), 32'(0));
    @(posedge clk); @(negedge clk);
    check("w16_wr_ack", 32'(w16_ack), 32'(1));
    @(posedge clk); #1; w16_stb = 1'b0;
    @(negedge clk);
    check("w16_ack_drop", 32'(w16_ack), 32'(0));

    // dw=16 read adr 2 fetches SRAM words 4 and 5
    @(posedge clk); #1;
    w16_stb = 1'b1; w16_we = 1'b0; w16_adr = 7'd2;
    @(posedge clk); @(negedge clk);
    check("w16_rd0", 32'({w16_ren, w16_raddr}), 32'({1'b1, 8'd4}));
    @(posedge clk); @(negedge clk);
    check("w16_rd1", 32'({w16_ren, w16_raddr}), 32'({1'b1, 8'd5}));
    @(posedge clk); @(negedge clk);
    check("w16_rd_early", 32'(w16_ack), 32'(0));
    @(posedge clk); @(negedge clk);
    check("w16_rd_ack", 32'(w16_ack), 32'(1));
    check("w16_rdt", w16_rdt, {16'h0005 ^ 16'hA5A5, 16'h0004 ^ 16'hA5A5});
    @(posedge clk); #1; w16_stb = 1'b0;

    // dw=8 directed cases
    wb_txn(1'b1, 7'd3, 32'hDEAD_BEEF, 4'b1111, 0);
    wb_txn(1'b0, 7'd3, 32'h0, 4'b1111, 0);
    wb_txn(1'b1, 7'd3, 32'h00AA_0000, 4'b0100, 0);
    wb_txn(1'b0, 7'd3, 32'h0, 4'b0000, 2);

    // Reset pulse while read beat 2 of adr 3 is on the port
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 7'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mid_beat2", 32'({sram_ren, sram_raddr}), 32'({1'b1, 9'd14}));
    #1 rst = 1'b1; wb_stb = 1'b0;
    #1 check("rst_mid_ren", 32'(sram_ren), 32'(0));
    @(posedge clk); #1; rst = 1'b0;
    saw_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wb_ack) saw_ack = 1'b1;
    end
    check("rst_no_ack", 32'(saw_ack), 32'(0));
    check("rst_rdt_clear", wb_rdt, 32'h0);
    wb_txn(1'b0, 7'd3, 32'h0, 4'b0000, 0);

    // Randomized traffic, Wishbone in the lower half and RF in the upper half
    repeat (60) wb_txn(1'($urandom_range(1)), 7'($urandom_range(63)), $urandom, 4'($urandom), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
